// File: rtl/mem_port_arbiter.sv
// Shares one memory port between fetch and load/store, with load/store priority and a fetch starvation bound.
// Latency: accept T, mem_req T+1, rsp pulse one cycle after mem_rsp_valid; one outstanding; backpressure via req_ready.
module mem_port_arbiter #(
    parameter int ADDR_WIDTH   = 32,
    parameter int DATA_WIDTH   = 32,
    parameter int STARVE_LIMIT = 4
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    if_req_valid,
    input  logic [ADDR_WIDTH-1:0]   if_req_adr,
    output logic                    if_req_ready,
    input  logic                    if_flush,
    output logic                    if_rsp_valid,
    output logic [DATA_WIDTH-1:0]   if_rsp_rdata,
    input  logic                    ls_req_valid,
    input  logic                    ls_req_we,
    input  logic [ADDR_WIDTH-1:0]   ls_req_adr,
    input  logic [DATA_WIDTH-1:0]   ls_req_wdata,
    input  logic [DATA_WIDTH/8-1:0] ls_req_be,
    output logic                    ls_req_ready,
    output logic                    ls_rsp_valid,
    output logic [DATA_WIDTH-1:0]   ls_rsp_rdata,
    output logic                    mem_req_valid,
    output logic                    mem_req_we,
    output logic [ADDR_WIDTH-1:0]   mem_req_adr,
    output logic [DATA_WIDTH-1:0]   mem_req_wdata,
    output logic [DATA_WIDTH/8-1:0] mem_req_be,
    input  logic                    mem_req_ready,
    input  logic                    mem_rsp_valid,
    input  logic [DATA_WIDTH-1:0]   mem_rsp_rdata
);
    localparam int BE_W  = DATA_WIDTH / 8;
    localparam int CNT_W = $clog2(STARVE_LIMIT + 1);
    localparam logic [CNT_W-1:0] LIMIT = CNT_W'(STARVE_LIMIT);

    typedef enum logic [1:0] {IDLE, REQ, RSP} state_t;

    state_t                r_state;
    logic [CNT_W-1:0]      r_starve_cnt;
    logic                  r_owner_ls;
    logic                  r_drop;
    logic                  r_mem_req_valid;
    logic                  r_mem_req_we;
    logic [ADDR_WIDTH-1:0] r_mem_req_adr;
    logic [DATA_WIDTH-1:0] r_mem_req_wdata;
    logic [BE_W-1:0]       r_mem_req_be;
    logic                  r_if_rsp_valid;
    logic [DATA_WIDTH-1:0] r_if_rsp_rdata;
    logic                  r_ls_rsp_valid;
    logic [DATA_WIDTH-1:0] r_ls_rsp_rdata;

    logic w_idle;
    logic w_grant_if;
    logic w_grant_ls;

    // A flushed fetch is not eligible; readies stay low while reset is held.
    assign w_idle     = (r_state == IDLE) && !reset;
    assign w_grant_if = w_idle && if_req_valid && !if_flush
                        && (!ls_req_valid || (r_starve_cnt == LIMIT));
    assign w_grant_ls = w_idle && ls_req_valid && !w_grant_if;

    assign if_req_ready  = w_grant_if;
    assign ls_req_ready  = w_grant_ls;
    assign mem_req_valid = r_mem_req_valid;
    assign mem_req_we    = r_mem_req_we;
    assign mem_req_adr   = r_mem_req_adr;
    assign mem_req_wdata = r_mem_req_wdata;
    assign mem_req_be    = r_mem_req_be;
    assign if_rsp_valid  = r_if_rsp_valid;
    assign if_rsp_rdata  = r_if_rsp_rdata;
    assign ls_rsp_valid  = r_ls_rsp_valid;
    assign ls_rsp_rdata  = r_ls_rsp_rdata;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state         <= IDLE;
            r_starve_cnt    <= '0;
            r_owner_ls      <= 1'b0;
            r_drop          <= 1'b0;
            r_mem_req_valid <= 1'b0;
            r_mem_req_we    <= 1'b0;
            r_mem_req_adr   <= '0;
            r_mem_req_wdata <= '0;
            r_mem_req_be    <= '0;
            r_if_rsp_valid  <= 1'b0;
            r_if_rsp_rdata  <= '0;
            r_ls_rsp_valid  <= 1'b0;
            r_ls_rsp_rdata  <= '0;
        end else begin
            r_if_rsp_valid <= 1'b0;
            r_ls_rsp_valid <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (w_grant_ls) begin
                        r_state         <= REQ;
                        r_mem_req_valid <= 1'b1;
                        r_owner_ls      <= 1'b1;
                        r_drop          <= 1'b0;
                        r_mem_req_we    <= ls_req_we;
                        r_mem_req_adr   <= ls_req_adr;
                        r_mem_req_wdata <= ls_req_wdata;
                        r_mem_req_be    <= ls_req_be;
                        // Count only grants that made a waiting fetch wait longer.
                        if (!if_req_valid) begin
                            r_starve_cnt <= '0;
                        end else if (r_starve_cnt != LIMIT) begin
                            r_starve_cnt <= r_starve_cnt + 1'b1;
                        end
                    end else if (w_grant_if) begin
                        r_state         <= REQ;
                        r_mem_req_valid <= 1'b1;
                        r_owner_ls      <= 1'b0;
                        r_drop          <= 1'b0;
                        r_mem_req_we    <= 1'b0;
                        r_mem_req_adr   <= if_req_adr;
                        r_mem_req_wdata <= '0;
                        r_mem_req_be    <= '1;
                        r_starve_cnt    <= '0;
                    end
                end
                REQ: begin
                    // The request is already visible to memory, so a flush only marks it stale.
                    if (if_flush && !r_owner_ls) begin
                        r_drop <= 1'b1;
                    end
                    if (mem_req_ready) begin
                        r_mem_req_valid <= 1'b0;
                        r_state         <= RSP;
                    end
                end
                RSP: begin
                    if (mem_rsp_valid) begin
                        r_state <= IDLE;
                        r_drop  <= 1'b0;
                        if (r_owner_ls) begin
                            r_ls_rsp_valid <= 1'b1;
                            r_ls_rsp_rdata <= r_mem_req_we ? '0 : mem_rsp_rdata;
                        end else if (!r_drop && !if_flush) begin
                            r_if_rsp_valid <= 1'b1;
                            r_if_rsp_rdata <= mem_rsp_rdata;
                        end
                    end else if (if_flush && !r_owner_ls) begin
                        r_drop <= 1'b1;
                    end
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed scenarios plus a randomized run against a transaction-level model of the arbiter.
module tb_mem_port_arbiter;
    localparam int AW  = 32;
    localparam int DW  = 32;
    localparam int BW  = DW / 8;
    localparam int LIM = 4;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          if_req_valid = 1'b0;
    logic [AW-1:0] if_req_adr = '0;
    logic          if_req_ready;
    logic          if_flush = 1'b0;
    logic          if_rsp_valid;
    logic [DW-1:0] if_rsp_rdata;
    logic          ls_req_valid = 1'b0;
    logic          ls_req_we = 1'b0;
    logic [AW-1:0] ls_req_adr = '0;
    logic [DW-1:0] ls_req_wdata = '0;
    logic [BW-1:0] ls_req_be = '0;
    logic          ls_req_ready;
    logic          ls_rsp_valid;
    logic [DW-1:0] ls_rsp_rdata;
    logic          mem_req_valid;
    logic          mem_req_we;
    logic [AW-1:0] mem_req_adr;
    logic [DW-1:0] mem_req_wdata;
    logic [BW-1:0] mem_req_be;
    logic          mem_req_ready = 1'b0;
    logic          mem_rsp_valid = 1'b0;
    logic [DW-1:0] mem_rsp_rdata = '0;

    int n_cmp  = 0;
    int n_fail = 0;

    mem_port_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .STARVE_LIMIT(LIM)) dut (
        .clk(clk), .reset(reset),
        .if_req_valid(if_req_valid), .if_req_adr(if_req_adr), .if_req_ready(if_req_ready),
        .if_flush(if_flush), .if_rsp_valid(if_rsp_valid), .if_rsp_rdata(if_rsp_rdata),
        .ls_req_valid(ls_req_valid), .ls_req_we(ls_req_we), .ls_req_adr(ls_req_adr),
        .ls_req_wdata(ls_req_wdata), .ls_req_be(ls_req_be), .ls_req_ready(ls_req_ready),
        .ls_rsp_valid(ls_rsp_valid), .ls_rsp_rdata(ls_rsp_rdata),
        .mem_req_valid(mem_req_valid), .mem_req_we(mem_req_we), .mem_req_adr(mem_req_adr),
        .mem_req_wdata(mem_req_wdata), .mem_req_be(mem_req_be), .mem_req_ready(mem_req_ready),
        .mem_rsp_valid(mem_rsp_valid), .mem_rsp_rdata(mem_rsp_rdata)
    );

    always #5 clk = ~clk;

    task automatic clear_inputs();
        if_req_valid  = 1'b0;
        if_req_adr    = '0;
        if_flush      = 1'b0;
        ls_req_valid  = 1'b0;
        ls_req_we     = 1'b0;
        ls_req_adr    = '0;
        ls_req_wdata  = '0;
        ls_req_be     = '0;
        mem_req_ready = 1'b0;
        mem_rsp_valid = 1'b0;
        mem_rsp_rdata = '0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        clear_inputs();
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic test_reset();
        logic [1+DW+1+DW+1+1+AW+DW+BW-1:0] outs;
        @(negedge clk);
        reset = 1'b1;
        if_req_valid = 1'b1;
        ls_req_valid = 1'b1;
        #1;
        outs = {if_rsp_valid, if_rsp_rdata, ls_rsp_valid, ls_rsp_rdata, mem_req_valid,
                mem_req_we, mem_req_adr, mem_req_wdata, mem_req_be};
        n_cmp++;
        if (outs !== '0) begin
            n_fail++;
            $display("FAIL reset_outputs got=%h want=0", outs);
        end
        n_cmp++;
        if ({if_req_ready, ls_req_ready} !== 2'b00) begin
            n_fail++;
            $display("FAIL reset_readies got=%b want=00", {if_req_ready, ls_req_ready});
        end
        @(negedge clk);
        clear_inputs();
        reset = 1'b0;
    endtask

    task automatic test_lone_fetch(input string tag);
        @(negedge clk);
        if_req_valid = 1'b1;
        if_req_adr   = 32'h100;
        #1;
        n_cmp++;
        if ({if_req_ready, ls_req_ready} !== 2'b10) begin
            n_fail++;
            $display("FAIL %s_accept got=%b want=10", tag, {if_req_ready, ls_req_ready});
        end
        @(negedge clk);
        if_req_valid  = 1'b0;
        mem_req_ready = 1'b1;
        #1;
        n_cmp++;
        if ({mem_req_valid, mem_req_we, mem_req_adr, mem_req_wdata, mem_req_be} !==
            {1'b1, 1'b0, 32'h100, 32'h0, 4'hF}) begin
            n_fail++;
            $display("FAIL %s_memreq got=%b/%b/%h/%h/%h want=1/0/100/0/f", tag,
                     mem_req_valid, mem_req_we, mem_req_adr, mem_req_wdata, mem_req_be);
        end
        @(negedge clk);
        mem_req_ready = 1'b0;
        mem_rsp_valid = 1'b1;
        mem_rsp_rdata = 32'h00500093;
        #1;
        n_cmp++;
        if (mem_req_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL %s_memreq_drop got=%b want=0", tag, mem_req_valid);
        end
        @(negedge clk);
        mem_rsp_valid = 1'b0;
        #1;
        n_cmp++;
        if ({if_rsp_valid, if_rsp_rdata, ls_rsp_valid} !== {1'b1, 32'h00500093, 1'b0}) begin
            n_fail++;
            $display("FAIL %s_rsp got=%b/%h/%b want=1/00500093/0", tag,
                     if_rsp_valid, if_rsp_rdata, ls_rsp_valid);
        end
        @(negedge clk);
        #1;
        n_cmp++;
        if (if_rsp_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL %s_rsp_pulse got=%b want=0", tag, if_rsp_valid);
        end
    endtask

    task automatic test_store();
        @(negedge clk);
        ls_req_valid = 1'b1;
        ls_req_we    = 1'b1;
        ls_req_adr   = 32'h2000;
        ls_req_wdata = 32'hDEADBEEF;
        ls_req_be    = 4'hF;
        #1;
        n_cmp++;
        if ({if_req_ready, ls_req_ready} !== 2'b01) begin
            n_fail++;
            $display("FAIL store_accept got=%b want=01", {if_req_ready, ls_req_ready});
        end
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            mem_req_ready = (k == 2);
            #1;
            n_cmp++;
            if ({mem_req_valid, mem_req_we, mem_req_adr, mem_req_wdata, mem_req_be, ls_req_ready} !==
                {1'b1, 1'b1, 32'h2000, 32'hDEADBEEF, 4'hF, 1'b0}) begin
                n_fail++;
                $display("FAIL store_hold%0d got=%b/%b/%h/%h/%h rdy=%b want=1/1/2000/deadbeef/f rdy=0",
                         k, mem_req_valid, mem_req_we, mem_req_adr, mem_req_wdata, mem_req_be, ls_req_ready);
            end
        end
        @(negedge clk);
        ls_req_valid  = 1'b0;
        mem_req_ready = 1'b0;
        #1;
        n_cmp++;
        if ({mem_req_valid, ls_rsp_valid} !== 2'b00) begin
            n_fail++;
            $display("FAIL store_rsp_wait got=%b want=00", {mem_req_valid, ls_rsp_valid});
        end
        @(negedge clk);
        mem_rsp_valid = 1'b1;
        mem_rsp_rdata = 32'h12345678;
        @(negedge clk);
        mem_rsp_valid = 1'b0;
        #1;
        n_cmp++;
        if ({ls_rsp_valid, ls_rsp_rdata, if_rsp_valid} !== {1'b1, 32'h0, 1'b0}) begin
            n_fail++;
            $display("FAIL store_rsp got=%b/%h/%b want=1/00000000/0", ls_rsp_valid, ls_rsp_rdata, if_rsp_valid);
        end
        @(negedge clk);
        #1;
        n_cmp++;
        if ({ls_rsp_valid, if_rsp_valid} !== 2'b00) begin
            n_fail++;
            $display("FAIL store_rsp_pulse got=%b want=00", {ls_rsp_valid, if_rsp_valid});
        end
        clear_inputs();
    endtask

    task automatic test_starvation();
        int  waits = 0;
        bit  exp_if;
        bit  prev_if = 1'b0;
        do_reset();
        for (int i = 0; i <= 10; i++) begin
            @(negedge clk);
            mem_rsp_valid = 1'b0;
            if_req_valid  = 1'b1;
            if_req_adr    = 32'h400 + 32'(i);
            ls_req_valid  = 1'b1;
            ls_req_we     = 1'b0;
            ls_req_adr    = 32'h800 + 32'(i);
            ls_req_be     = 4'h3;
            #1;
            if (i > 0) begin
                n_cmp++;
                if ({if_rsp_valid, ls_rsp_valid} !== (prev_if ? 2'b10 : 2'b01)) begin
                    n_fail++;
                    $display("FAIL starve_rsp_owner%0d got=%b want=%b", i - 1,
                             {if_rsp_valid, ls_rsp_valid}, prev_if ? 2'b10 : 2'b01);
                end
            end
            if (i == 10) break;
            exp_if = (waits == LIM);
            waits  = exp_if ? 0 : waits + 1;
            n_cmp++;
            if ({if_req_ready, ls_req_ready} !== (exp_if ? 2'b10 : 2'b01)) begin
                n_fail++;
                $display("FAIL starve_grant%0d got=%b want=%b", i,
                         {if_req_ready, ls_req_ready}, exp_if ? 2'b10 : 2'b01);
            end
            prev_if = exp_if;
            @(negedge clk);
            mem_req_ready = 1'b1;
            #1;
            n_cmp++;
            if ({if_req_ready, ls_req_ready, mem_req_adr} !==
                {2'b00, exp_if ? 32'h400 + 32'(i) : 32'h800 + 32'(i)}) begin
                n_fail++;
                $display("FAIL starve_req%0d rdy=%b adr=%h", i, {if_req_ready, ls_req_ready}, mem_req_adr);
            end
            @(negedge clk);
            mem_req_ready = 1'b0;
            mem_rsp_valid = 1'b1;
            mem_rsp_rdata = 32'(i);
        end
        clear_inputs();
    endtask

    task automatic flush_fetch(input string tag, input int flush_phase);
        // flush_phase: 0 = in REQ, 1 = in RSP before response, 2 = on the response cycle
        @(negedge clk);
        if_req_valid = 1'b1;
        if_req_adr   = 32'h300;
        #1;
        n_cmp++;
        if (if_req_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL %s_accept got=%b want=1", tag, if_req_ready);
        end
        @(negedge clk);
        if_req_valid = 1'b0;
        if_flush     = (flush_phase == 0);
        @(negedge clk);
        if_flush      = 1'b0;
        mem_req_ready = 1'b1;
        #1;
        n_cmp++;
        if (mem_req_valid !== 1'b1) begin
            n_fail++;
            $display("FAIL %s_handshake got=%b want=1", tag, mem_req_valid);
        end
        @(negedge clk);
        mem_req_ready = 1'b0;
        if_flush      = (flush_phase == 1);
        @(negedge clk);
        if_flush      = (flush_phase == 2);
        mem_rsp_valid = 1'b1;
        mem_rsp_rdata = 32'hCAFE0001;
        @(negedge clk);
        if_flush      = 1'b0;
        mem_rsp_valid = 1'b0;
        #1;
        n_cmp++;
        if ({if_rsp_valid, ls_rsp_valid} !== 2'b00) begin
            n_fail++;
            $display("FAIL %s_no_rsp got=%b want=00", tag, {if_rsp_valid, ls_rsp_valid});
        end
    endtask

    task automatic test_flush();
        flush_fetch("flush_req", 0);
        flush_fetch("flush_rsp", 1);
        flush_fetch("flush_rspcyc", 2);
        @(negedge clk);
        if_req_valid = 1'b1;
        if_req_adr   = 32'h500;
        ls_req_valid = 1'b1;
        ls_req_we    = 1'b0;
        ls_req_adr   = 32'h600;
        ls_req_be    = 4'hF;
        if_flush     = 1'b1;
        #1;
        n_cmp++;
        if ({if_req_ready, ls_req_ready} !== 2'b01) begin
            n_fail++;
            $display("FAIL flush_idle got=%b want=01", {if_req_ready, ls_req_ready});
        end
        @(negedge clk);
        clear_inputs();
        mem_req_ready = 1'b1;
        @(negedge clk);
        mem_req_ready = 1'b0;
        mem_rsp_valid = 1'b1;
        mem_rsp_rdata = 32'h0BADF00D;
        @(negedge clk);
        mem_rsp_valid = 1'b0;
        #1;
        n_cmp++;
        if ({ls_rsp_valid, ls_rsp_rdata} !== {1'b1, 32'h0BADF00D}) begin
            n_fail++;
            $display("FAIL flush_idle_ls_rsp got=%b/%h want=1/0badf00d", ls_rsp_valid, ls_rsp_rdata);
        end
        test_lone_fetch("flush_after");
    endtask

    task automatic test_reset_mid_rsp();
        logic [1+DW+1+DW+1+1+AW+DW+BW-1:0] outs;
        @(negedge clk);
        ls_req_valid = 1'b1;
        ls_req_we    = 1'b0;
        ls_req_adr   = 32'h40;
        ls_req_be    = 4'hF;
        @(negedge clk);
        ls_req_valid  = 1'b0;
        mem_req_ready = 1'b1;
        @(negedge clk);
        mem_req_ready = 1'b0;
        if_req_valid  = 1'b1;
        ls_req_valid  = 1'b1;
        #2;
        reset = 1'b1;
        #1;
        outs = {if_rsp_valid, if_rsp_rdata, ls_rsp_valid, ls_rsp_rdata, mem_req_valid,
                mem_req_we, mem_req_adr, mem_req_wdata, mem_req_be};
        n_cmp++;
        if ({outs, if_req_ready, ls_req_ready} !== '0) begin
            n_fail++;
            $display("FAIL midrst_outputs got=%h rdy=%b want=0", outs, {if_req_ready, ls_req_ready});
        end
        @(negedge clk);
        clear_inputs();
        reset = 1'b0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            #1;
            n_cmp++;
            if ({ls_rsp_valid, if_rsp_valid, mem_req_valid} !== 3'b000) begin
                n_fail++;
                $display("FAIL midrst_quiet%0d got=%b want=000", k, {ls_rsp_valid, if_rsp_valid, mem_req_valid});
            end
        end
        test_lone_fetch("midrst_fetch");
    endtask

    task automatic test_random();
        // Model: at most one transaction in flight, either waiting for memory to accept or for its response.
        bit            pend_v = 0, infl_v = 0;
        bit            t_ls = 0, t_we = 0, t_drop = 0;
        logic [AW-1:0] t_adr = '0;
        logic [DW-1:0] t_wd = '0;
        logic [BW-1:0] t_be = '0;
        bit            e_if_v = 0, e_ls_v = 0;
        logic [DW-1:0] e_if_d = '0, e_ls_d = '0;
        int            waits = 0;
        bit            if_acc = 0, ls_acc = 0;
        bit            free, x_if, x_ls;
        do_reset();
        for (int cyc = 0; cyc < 3000; cyc++) begin
            @(negedge clk);
            if (if_acc) if_req_valid = 1'b0;
            if (ls_acc) ls_req_valid = 1'b0;
            if_acc = 0;
            ls_acc = 0;
            if (!if_req_valid && $urandom_range(0, 2) == 0) begin
                if_req_valid = 1'b1;
                if_req_adr   = $urandom;
            end
            if (!ls_req_valid && $urandom_range(0, 1) == 0) begin
                ls_req_valid = 1'b1;
                ls_req_we    = 1'($urandom_range(0, 1));
                ls_req_adr   = $urandom;
                ls_req_wdata = $urandom;
                ls_req_be    = 4'($urandom_range(0, 15));
            end
            if_flush      = ($urandom_range(0, 7) == 0);
            mem_req_ready = 1'($urandom_range(0, 1));
            mem_rsp_valid = infl_v ? 1'($urandom_range(0, 1)) : ($urandom_range(0, 15) == 0);
            mem_rsp_rdata = $urandom;
            #1;
            free = !pend_v && !infl_v;
            x_if = free && if_req_valid && !if_flush && (!ls_req_valid || waits == LIM);
            x_ls = free && ls_req_valid && !x_if;
            n_cmp++;
            if ({if_req_ready, ls_req_ready} !== {x_if, x_ls}) begin
                n_fail++;
                $display("FAIL rnd_ready cyc=%0d got=%b want=%b", cyc, {if_req_ready, ls_req_ready}, {x_if, x_ls});
            end
            n_cmp++;
            if (mem_req_valid !== pend_v) begin
                n_fail++;
                $display("FAIL rnd_memvalid cyc=%0d got=%b want=%b", cyc, mem_req_valid, pend_v);
            end
            if (pend_v) begin
                n_cmp++;
                if ({mem_req_we, mem_req_adr, mem_req_wdata, mem_req_be} !== {t_we, t_adr, t_wd, t_be}) begin
                    n_fail++;
                    $display("FAIL rnd_memreq cyc=%0d got=%b/%h/%h/%h want=%b/%h/%h/%h", cyc,
                             mem_req_we, mem_req_adr, mem_req_wdata, mem_req_be, t_we, t_adr, t_wd, t_be);
                end
            end
            n_cmp++;
            if ({if_rsp_valid, ls_rsp_valid} !== {e_if_v, e_ls_v}) begin
                n_fail++;
                $display("FAIL rnd_rspvalid cyc=%0d got=%b want=%b", cyc, {if_rsp_valid, ls_rsp_valid}, {e_if_v, e_ls_v});
            end
            if (e_if_v) begin
                n_cmp++;
                if (if_rsp_rdata !== e_if_d) begin
                    n_fail++;
                    $display("FAIL rnd_if_rdata cyc=%0d got=%h want=%h", cyc, if_rsp_rdata, e_if_d);
                end
            end
            if (e_ls_v) begin
                n_cmp++;
                if (ls_rsp_rdata !== e_ls_d) begin
                    n_fail++;
                    $display("FAIL rnd_ls_rdata cyc=%0d got=%h want=%h", cyc, ls_rsp_rdata, e_ls_d);
                end
            end
            e_if_v = 0;
            e_ls_v = 0;
            if (infl_v) begin
                if (if_flush && !t_ls) t_drop = 1;
                if (mem_rsp_valid) begin
                    infl_v = 0;
                    if (t_ls) begin
                        e_ls_v = 1;
                        e_ls_d = t_we ? '0 : mem_rsp_rdata;
                    end else if (!t_drop) begin
                        e_if_v = 1;
                        e_if_d = mem_rsp_rdata;
                    end
                end
            end else if (pend_v) begin
                if (if_flush && !t_ls) t_drop = 1;
                if (mem_req_ready) begin
                    pend_v = 0;
                    infl_v = 1;
                end
            end else if (x_if || x_ls) begin
                pend_v = 1;
                t_ls   = x_ls;
                t_drop = 0;
                if (x_ls) begin
                    t_we   = ls_req_we;
                    t_adr  = ls_req_adr;
                    t_wd   = ls_req_wdata;
                    t_be   = ls_req_be;
                    ls_acc = 1;
                    waits  = if_req_valid ? ((waits < LIM) ? waits + 1 : LIM) : 0;
                end else begin
                    t_we   = 0;
                    t_adr  = if_req_adr;
                    t_wd   = '0;
                    t_be   = '1;
                    if_acc = 1;
                    waits  = 0;
                end
            end
        end
        clear_inputs();
    endtask

    initial begin
        clear_inputs();
        test_reset();
        test_lone_fetch("lone_fetch");
        test_store();
        test_starvation();
        test_flush();
        test_reset_mid_rsp();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Shares the single data-memory port between the instruction fetch requester and the EXU load/store requester. Request transfers use valid/ready handshakes, and the memory returns one response per request. The arbiter allows one outstanding transaction and gives load/store priority, with a starvation bound for fetch. It routes each response back to its owner, and a fetch flush discards a stale fetch.

## Interface
Parameters:
- ADDR_WIDTH, 32, address width
- DATA_WIDTH, 32, data width
- STARVE_LIMIT, 4, max consecutive load/store grants while fetch waits (≥1)

Ports:
- clk  in  1  clock, rising edge
- reset  in  1  asynchronous, active-high; one clock; reset is asynchronous and active-high
- if_req_valid  in  1  fetch request
- if_req_adr  in  ADDR_WIDTH  fetch address
- if_req_ready  out  1  fetch request accepted this cycle (combinational)
- if_flush  in  1  discard current/outstanding fetch
- if_rsp_valid  out  1  fetch data valid, one-cycle pulse
- if_rsp_rdata  out  DATA_WIDTH  fetch data
- ls_req_valid  in  1  load/store request
- ls_req_we  in  1  1 = store
- ls_req_adr  in  ADDR_WIDTH  address
- ls_req_wdata  in  DATA_WIDTH  store data
- ls_req_be  in  DATA_WIDTH/8  byte enables
- ls_req_ready  out  1  load/store accepted this cycle (combinational)
- ls_rsp_valid  out  1  load data / store ack, one-cycle pulse
- ls_rsp_rdata  out  DATA_WIDTH  load data (store: don't-care, driven 0)
- mem_req_valid, mem_req_we  out  1  registered memory request
- mem_req_adr  out  ADDR_WIDTH; mem_req_wdata  out  DATA_WIDTH; mem_req_be  out  DATA_WIDTH/8
- mem_req_ready  in  1  memory accepts request
- mem_rsp_valid  in  1  memory response (one per accepted request, loads and stores)
- mem_rsp_rdata  in  DATA_WIDTH  response data

## Operation
- FSM states: IDLE, REQ, RSP.
- IDLE → REQ: taken when any req_valid is high.
  - Grant one requester and assert its ready for that cycle.
  - Latch adr/we/wdata/be and owner into registers. Fetch grants latch we=0, be=all-ones, wdata=0.
- Arbitration in IDLE:
  - Only one valid: grant it.
  - Both valid: grant load/store, unless starve_cnt == STARVE_LIMIT, in which case grant fetch.
  - If ls_req_valid && if_req_valid at an ls grant: starve_cnt++ (saturating).
  - Any fetch grant, or an ls grant with fetch idle: starve_cnt = 0.
- REQ:
  - mem_req_* outputs are driven from the registers, with mem_req_valid=1.
  - On mem_req_ready → RSP, and mem_req_valid drops next cycle.
  - if_flush with owner=fetch while in REQ: still complete the handshake (the request is already visible to memory) and set drop=1.
- RSP: on mem_rsp_valid → IDLE, and register the response.
  - owner=ls: ls_rsp_valid=1 and ls_rsp_rdata=mem_rsp_rdata next cycle. For a store, ls_rsp_rdata=0.
  - owner=fetch and drop=0 and no if_flush this cycle: if_rsp_valid=1, if_rsp_rdata=mem_rsp_rdata next cycle.
  - owner=fetch and (drop=1 or if_flush): no if_rsp_valid. Clear drop.
- if_flush in RSP with owner=fetch sets drop=1.
- if_flush in IDLE: if_req_ready forced 0 that cycle; ls may still be granted.
- mem_rsp_valid in IDLE or REQ is a protocol violation: ignored, no state change.
- if_rsp_valid and ls_rsp_valid are never high in the same cycle.

## Timing
- Reset values, all 0: every output, state=IDLE, starve_cnt, drop, owner.
  - Reset mid-transaction abandons it with no response pulse; memory must be reset together.
- Best-case latency:
  - Accept at cycle T; mem_req_valid at T+1.
  - mem_req_ready at T+1 → RSP at T+2.
  - mem_rsp_valid at T+2 → rsp_valid pulse at T+3.
  - Next grant possible at T+3 (IDLE). Throughput one transaction per 3 cycles minimum.
- mem_req_* outputs hold stable while mem_req_valid=1 and mem_req_ready=0.
- req_ready outputs are 0 in REQ and RSP.
- Memory stalls (ready or response) extend REQ/RSP indefinitely; no timeout.

## Test plan
- Lone fetch:
  - Stimulus: if_req_valid, adr=0x100 at T; mem_req_ready at T+1; mem_rsp_valid, rdata=0x00500093 at T+2.
  - Required: if_req_ready at T, mem_req_valid T+1 with adr=0x100, we=0; if_rsp_valid at T+3 with rdata=0x00500093.
- Store:
  - Stimulus: ls_req we=1, adr=0x2000, wdata=0xDEADBEEF, be=0xF; memory stalls mem_req_ready 2 cycles.
  - Required: mem_req_* held stable for 3 cycles; ls_rsp_valid pulses with rdata=0; if_rsp_valid stays 0.
- Priority/starvation, STARVE_LIMIT=4:
  - Stimulus: both requesters valid continuously.
  - Required: grant order LS,LS,LS,LS,IF,LS,LS,LS,LS,IF.
- Flush:
  - Stimulus: fetch granted; if_flush asserted in REQ, then separately in RSP.
  - Required: memory handshake completes; no if_rsp_valid pulse; next fetch returns data normally.
- Reset mid-RSP:
  - Stimulus: assert reset during RSP of a load.
  - Required: all outputs 0 immediately (async); no ls_rsp_valid after release; first grant after release behaves as in the lone fetch case.
